// File: rtl/ex_alu_sched.sv
// Two-port round-robin scheduler in front of a shared integer ALU stage-1 datapath.
// The combinational ALU result is captured into one output register tagged with source port and issue tag.
module ex_alu_sched #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [63:0]      p0_in1,
  input  logic [63:0]      p0_in2,
  input  logic [2:0]       p0_unit,
  input  logic [1:0]       p0_op,
  input  logic [TAG_W-1:0] p0_tag,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [63:0]      p1_in1,
  input  logic [63:0]      p1_in2,
  input  logic [2:0]       p1_unit,
  input  logic [1:0]       p1_op,
  input  logic [TAG_W-1:0] p1_tag,
  output logic             alu_enable,
  output logic [63:0]      alu_in1,
  output logic [63:0]      alu_in2,
  output logic [2:0]       alu_unit,
  output logic [1:0]       alu_op,
  input  logic [63:0]      alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  logic             last_grant_r;
  logic             res_valid_r;
  logic [63:0]      res_data_r;
  logic             res_src_r;
  logic [TAG_W-1:0] res_tag_r;

  logic             can_accept_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             accept0_s;
  logic             accept1_s;

  // Gating with rst_n keeps both ports stalled while reset is held.
  assign can_accept_s = rst_n & (~res_valid_r | res_ready);

  // Round-robin arbitration: on contention the port that did not win last time goes.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (can_accept_s) begin
      if (p0_valid && p1_valid) begin
        if (last_grant_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else if (p0_valid) begin
        grant0_s = 1'b1;
      end else if (p1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign p0_ready  = grant0_s;
  assign p1_ready  = grant1_s;
  assign accept0_s = p0_valid & grant0_s;
  assign accept1_s = p1_valid & grant1_s;

  // ALU operand mux: the granted port's fields, otherwise all zero.
  always_comb begin
    alu_enable = 1'b0;
    alu_in1    = 64'd0;
    alu_in2    = 64'd0;
    alu_unit   = 3'd0;
    alu_op     = 2'd0;
    if (grant0_s) begin
      alu_enable = 1'b1;
      alu_in1    = p0_in1;
      alu_in2    = p0_in2;
      alu_unit   = p0_unit;
      alu_op     = p0_op;
    end else if (grant1_s) begin
      alu_enable = 1'b1;
      alu_in1    = p1_in1;
      alu_in2    = p1_in2;
      alu_unit   = p1_unit;
      alu_op     = p1_op;
    end else begin
      alu_enable = 1'b0;
    end
  end

  // Result register and priority state; data fields only change on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      res_valid_r  <= 1'b0;
      res_data_r   <= 64'd0;
      res_src_r    <= 1'b0;
      res_tag_r    <= '0;
    end else if (accept0_s) begin
      last_grant_r <= 1'b0;
      res_valid_r  <= 1'b1;
      res_data_r   <= alu_out;
      res_src_r    <= 1'b0;
      res_tag_r    <= p0_tag;
    end else if (accept1_s) begin
      last_grant_r <= 1'b1;
      res_valid_r  <= 1'b1;
      res_data_r   <= alu_out;
      res_src_r    <= 1'b1;
      res_tag_r    <= p1_tag;
    end else if (res_ready) begin
      res_valid_r  <= 1'b0;
    end else begin
      res_valid_r  <= res_valid_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_src   = res_src_r;
  assign res_tag   = res_tag_r;

endmodule

// File: tb/tb_ex_alu_sched.sv
// Directed bench for ex_alu_sched with a small behavioural ALU driving alu_out.
// Unit encoding used here: 0 add/sub, 1 slt/sgt, 2 shifts, 3 bitwise.
module tb_ex_alu_sched;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             p0_valid, p1_valid;
  logic             p0_ready, p1_ready;
  logic [63:0]      p0_in1, p0_in2, p1_in1, p1_in2;
  logic [2:0]       p0_unit, p1_unit;
  logic [1:0]       p0_op, p1_op;
  logic [TAG_W-1:0] p0_tag, p1_tag;
  logic             alu_enable;
  logic [63:0]      alu_in1, alu_in2, alu_out;
  logic [2:0]       alu_unit;
  logic [1:0]       alu_op;
  logic             res_valid, res_ready, res_src;
  logic [63:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  int errors = 0;
  int checks = 0;

  ex_alu_sched #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_in1(p0_in1), .p0_in2(p0_in2),
    .p0_unit(p0_unit), .p0_op(p0_op), .p0_tag(p0_tag),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_in1(p1_in1), .p1_in2(p1_in2),
    .p1_unit(p1_unit), .p1_op(p1_op), .p1_tag(p1_tag),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_unit(alu_unit), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_tag(res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU stage.
  always_comb begin
    alu_out = 64'd0;
    case (alu_unit)
      3'd0: alu_out = (alu_op == 2'd1) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
      3'd1: alu_out = (alu_op == 2'd1) ? {63'd0, $signed(alu_in1) > $signed(alu_in2)}
                                       : {63'd0, $signed(alu_in1) < $signed(alu_in2)};
      3'd2: alu_out = (alu_op == 2'd0) ? alu_in1 << alu_in2[5:0] : alu_in1 >> alu_in2[5:0];
      3'd3: alu_out = (alu_op == 2'd0) ? alu_in1 & alu_in2 :
                      (alu_op == 2'd1) ? alu_in1 | alu_in2 : alu_in1 ^ alu_in2;
      default: alu_out = 64'd0;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_p0(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] u, input logic [1:0] o, input logic [TAG_W-1:0] t);
    p0_valid = v; p0_in1 = a; p0_in2 = b; p0_unit = u; p0_op = o; p0_tag = t;
  endtask

  task automatic set_p1(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] u, input logic [1:0] o, input logic [TAG_W-1:0] t);
    p1_valid = v; p1_in1 = a; p1_in2 = b; p1_unit = u; p1_op = o; p1_tag = t;
  endtask

  initial begin
    logic [63:0] held_data;
    rst_n = 1'b0;
    res_ready = 1'b1;
    set_p0(1'b1, 64'd1, 64'd1, 3'd0, 2'd0, 5'd0);
    set_p1(1'b1, 64'd1, 64'd1, 3'd0, 2'd0, 5'd0);
    repeat (2) tick();
    check_val("rst_res_valid", res_valid, 64'd0);
    check_val("rst_res_data", res_data, 64'd0);
    check_val("rst_res_src", res_src, 64'd0);
    check_val("rst_res_tag", res_tag, 64'd0);
    check_val("rst_p0_ready", p0_ready, 64'd0);
    check_val("rst_p1_ready", p1_ready, 64'd0);
    check_val("rst_alu_en", alu_enable, 64'd0);
    set_p0(1'b0, 64'd0, 64'd0, 3'd0, 2'd0, 5'd0);
    set_p1(1'b0, 64'd0, 64'd0, 3'd0, 2'd0, 5'd0);
    rst_n = 1'b1;
    tick();
    check_val("idle_alu_in1", alu_in1, 64'd0);

    // 1: single add from p0
    set_p0(1'b1, 64'd5, 64'd3, 3'd0, 2'd0, 5'd7);
    @(negedge clk);
    check_val("t1_p0_ready", p0_ready, 64'd1);
    check_val("t1_alu_en", alu_enable, 64'd1);
    check_val("t1_alu_in1", alu_in1, 64'd5);
    tick();
    p0_valid = 1'b0;
    check_val("t1_res_valid", res_valid, 64'd1);
    check_val("t1_res_data", res_data, 64'd8);
    check_val("t1_res_src", res_src, 64'd0);
    check_val("t1_res_tag", res_tag, 64'd7);
    tick();
    check_val("t1_drain", res_valid, 64'd0);
    check_val("t1_data_kept", res_data, 64'd8);

    // 2: both valid, alternating grants with no bubbles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_p0(1'b1, 64'(i), 64'd1, 3'd0, 2'd0, 5'd1);
      set_p1(1'b1, 64'(100 + i), 64'd1, 3'd0, 2'd0, 5'd2);
      @(negedge clk);
      check_val($sformatf("t2_p0_ready_%0d", i), p0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
      check_val($sformatf("t2_p1_ready_%0d", i), p1_ready, (i % 2 == 1) ? 64'd1 : 64'd0);
      tick();
      check_val($sformatf("t2_valid_%0d", i), res_valid, 64'd1);
      check_val($sformatf("t2_src_%0d", i), res_src, (i % 2 == 1) ? 64'd1 : 64'd0);
      check_val($sformatf("t2_data_%0d", i), res_data, (i % 2 == 1) ? 64'(101 + i) : 64'(i + 1));
      check_val($sformatf("t2_tag_%0d", i), res_tag, (i % 2 == 1) ? 64'd2 : 64'd1);
    end

    // 3: back-pressure holds everything; p1 won last so p0 is next
    res_ready = 1'b0;
    held_data = 64'd104;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("t3_p0_ready", p0_ready, 64'd0);
      check_val("t3_p1_ready", p1_ready, 64'd0);
      check_val("t3_alu_en", alu_enable, 64'd0);
      tick();
      check_val("t3_valid_held", res_valid, 64'd1);
      check_val("t3_data_held", res_data, held_data);
      check_val("t3_src_held", res_src, 64'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check_val("t3_resume_p0", p0_ready, 64'd1);
    check_val("t3_resume_p1", p1_ready, 64'd0);
    tick();
    check_val("t3_resume_src", res_src, 64'd0);

    // 4: wrap on SUB, signed compare
    p0_valid = 1'b0;
    set_p1(1'b1, 64'd0, 64'd1, 3'd0, 2'd1, 5'd9);
    tick();
    check_val("t4_sub", res_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("t4_sub_src", res_src, 64'd1);
    check_val("t4_sub_tag", res_tag, 64'd9);
    p1_valid = 1'b0;
    set_p0(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'd1, 2'd0, 5'd3);
    tick();
    check_val("t4_slt", res_data, 64'd1);
    check_val("t4_slt_src", res_src, 64'd0);

    // 5: p1 alone three times, then p0 wins contention
    p0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_p1(1'b1, 64'hF0, 64'h3C, 3'd3, 2'(i), 5'(10 + i));
      @(negedge clk);
      check_val($sformatf("t5_p1_ready_%0d", i), p1_ready, 64'd1);
      tick();
      check_val($sformatf("t5_src_%0d", i), res_src, 64'd1);
      check_val($sformatf("t5_data_%0d", i), res_data,
                (i == 0) ? 64'h30 : (i == 1) ? 64'hFC : 64'hCC);
    end
    set_p0(1'b1, 64'd1, 64'd4, 3'd2, 2'd0, 5'd20);
    @(negedge clk);
    check_val("t5_p0_wins", p0_ready, 64'd1);
    check_val("t5_p1_loses", p1_ready, 64'd0);
    tick();
    check_val("t5_shift", res_data, 64'd16);
    check_val("t5_shift_src", res_src, 64'd0);

    // 6: reset with a held result and both ports valid
    res_ready = 1'b0;
    check_val("t6_pre_valid", res_valid, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_valid_dropped", res_valid, 64'd0);
    check_val("t6_p0_ready_rst", p0_ready, 64'd0);
    check_val("t6_p1_ready_rst", p1_ready, 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t6_first_p0", p0_ready, 64'd1);
    check_val("t6_first_p1", p1_ready, 64'd0);
    tick();
    check_val("t6_src", res_src, 64'd0);
    check_val("t6_tag", res_tag, 64'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
